// File: rtl/proj_fm_moving_ram_if.sv
// Drive/observe bundle for the projection feature-map RAM.
// The master drives pointer load and write controls, and the slave returns read data and status.
interface proj_fm_moving_ram_if #(
  parameter int ENTRIES   = 8,
  parameter int DATA_BITS = 8
);
  localparam int ADDR_BITS = $clog2(ENTRIES);

  logic [ADDR_BITS-1:0] in_addr;
  logic                 in_load;
  logic                 in_we;
  logic [DATA_BITS-1:0] in_wdata;
  logic [DATA_BITS-1:0] out_rdata;
  logic [ADDR_BITS-1:0] out_waddr;
  logic [ADDR_BITS-1:0] out_raddr;
  logic                 out_filled;

  modport master (
    output in_addr, in_load, in_we, in_wdata,
    input  out_rdata, out_waddr, out_raddr, out_filled
  );

  modport slave (
    input  in_addr, in_load, in_we, in_wdata,
    output out_rdata, out_waddr, out_raddr, out_filled
  );
endinterface

// File: rtl/proj_fm_moving_ram.sv
// Feature-map RAM with self-advancing write/read pointers; data survives reset.
// Define PROJ_FM_RAM_RDATA_REG_EN for a registered out_rdata with one cycle of latency.
module proj_fm_moving_ram #(
  parameter int ENTRIES   = 8,
  parameter int DATA_BITS = 8
) (
  input logic                 in_clk,
  input logic                 in_rst,
  proj_fm_moving_ram_if.slave bus
);
  localparam int ADDR_BITS = $clog2(ENTRIES);
  localparam logic [ADDR_BITS-1:0] LAST =
    ADDR_BITS'(ENTRIES - 1);

  logic [DATA_BITS-1:0] data [ENTRIES];
  logic [ADDR_BITS-1:0] waddr;
  logic [ADDR_BITS-1:0] raddr;
  logic [ADDR_BITS-1:0] load_addr;
  logic [ADDR_BITS-1:0] waddr_nxt;
  logic [ADDR_BITS-1:0] raddr_nxt;
  logic                 filled;
  logic                 do_write;

  // A preload address past the end of the array loads zero.
  always_comb begin
    load_addr = bus.in_addr;
    if (32'(bus.in_addr) >= ENTRIES)
      load_addr = '0;
    waddr_nxt = (waddr == LAST) ? '0
              : waddr + ADDR_BITS'(1);
    raddr_nxt = (raddr == LAST) ? '0
              : raddr + ADDR_BITS'(1);
  end

  assign do_write = !in_rst && !bus.in_load && bus.in_we;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      waddr  <= '0;
      raddr  <= '0;
      filled <= 1'b0;
    end else if (bus.in_load) begin
      waddr <= load_addr;
      raddr <= load_addr;
    end else if (bus.in_we) begin
      waddr <= waddr_nxt;
      if (waddr == LAST)
        filled <= 1'b1;
    end else begin
      raddr <= raddr_nxt;
    end
  end

  // The array has no reset, so a block written before reset can still be read back after it.
  always_ff @(posedge in_clk) begin
    if (do_write)
      data[waddr] <= bus.in_wdata;
  end

`ifdef PROJ_FM_RAM_RDATA_REG_EN
  logic [DATA_BITS-1:0] rdata_q;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)
      rdata_q <= '0;
    else if (!bus.in_load)
      rdata_q <= data[raddr];
  end

  assign bus.out_rdata = rdata_q;
`else
  assign bus.out_rdata = data[raddr];
`endif

  assign bus.out_waddr  = waddr;
  assign bus.out_raddr  = raddr;
  assign bus.out_filled = filled;
endmodule

// File: tb/tb_proj_fm_moving_ram.sv
// Directed scoreboard bench for proj_fm_moving_ram (8- and 5-entry instances).
module tb_proj_fm_moving_ram;
`ifdef PROJ_FM_RAM_RDATA_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  typedef struct {
    logic [31:0] w8, r8, d8, f8;
    logic [31:0] w5, r5, d5, f5;
    bit          c5;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  proj_fm_moving_ram_if #(.ENTRIES(8), .DATA_BITS(8)) b8 ();
  proj_fm_moving_ram_if #(.ENTRIES(5), .DATA_BITS(8)) b5 ();

  proj_fm_moving_ram #(.ENTRIES(8), .DATA_BITS(8)) u8 (
    .in_clk(clk), .in_rst(rst), .bus(b8)
  );
  proj_fm_moving_ram #(.ENTRIES(5), .DATA_BITS(8)) u5 (
    .in_clk(clk), .in_rst(rst), .bus(b5)
  );

  int passed = 0;
  int total  = 0;
  exp_t sb[$];

  logic [7:0] m8 [8];
  logic [7:0] m5 [5];
  int w8, r8, w5, r5;
  bit f8, f5;
  logic [7:0] q8, q5;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic model8();
    if (rst) begin
      w8 = 0; r8 = 0; f8 = 0; q8 = 8'h00;
    end else if (b8.in_load) begin
      w8 = (int'(b8.in_addr) >= 8) ? 0 : int'(b8.in_addr);
      r8 = w8;
    end else if (b8.in_we) begin
      q8 = m8[r8];
      m8[w8] = b8.in_wdata;
      if (w8 == 7) f8 = 1;
      w8 = (w8 == 7) ? 0 : w8 + 1;
    end else begin
      q8 = m8[r8];
      r8 = (r8 == 7) ? 0 : r8 + 1;
    end
  endtask

  task automatic model5();
    if (rst) begin
      w5 = 0; r5 = 0; f5 = 0; q5 = 8'h00;
    end else if (b5.in_load) begin
      w5 = (int'(b5.in_addr) >= 5) ? 0 : int'(b5.in_addr);
      r5 = w5;
    end else if (b5.in_we) begin
      q5 = m5[r5];
      m5[w5] = b5.in_wdata;
      if (w5 == 4) f5 = 1;
      w5 = (w5 == 4) ? 0 : w5 + 1;
    end else begin
      q5 = m5[r5];
      r5 = (r5 == 4) ? 0 : r5 + 1;
    end
  endtask

  task automatic tick(string tag, bit c5);
    exp_t e;
    model8();
    model5();
    e.w8 = 32'(w8); e.r8 = 32'(r8);
    e.d8 = REG ? {24'h0, q8} : {24'h0, m8[r8]};
    e.f8 = {31'h0, f8};
    e.w5 = 32'(w5); e.r5 = 32'(r5);
    e.d5 = REG ? {24'h0, q5} : {24'h0, m5[r5]};
    e.f5 = {31'h0, f5};
    e.c5 = c5; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "_waddr"}, 32'(b8.out_waddr), e.w8);
    chk({e.tag, "_raddr"}, 32'(b8.out_raddr), e.r8);
    chk({e.tag, "_filled"}, 32'(b8.out_filled), e.f8);
    if (!$isunknown(e.d8))
      chk({e.tag, "_rdata"}, 32'(b8.out_rdata), e.d8);
    if (e.c5) begin
      chk({e.tag, "_w5"}, 32'(b5.out_waddr), e.w5);
      chk({e.tag, "_r5"}, 32'(b5.out_raddr), e.r5);
      chk({e.tag, "_f5"}, 32'(b5.out_filled), e.f5);
      if (!$isunknown(e.d5))
        chk({e.tag, "_d5"}, 32'(b5.out_rdata), e.d5);
    end
  endtask

  initial begin
    rst = 1'b1;
    b8.in_addr = '0; b8.in_load = 1'b0;
    b8.in_we = 1'b0; b8.in_wdata = '0;
    b5.in_addr = '0; b5.in_load = 1'b1;
    b5.in_we = 1'b0; b5.in_wdata = '0;
    #2;
    chk("rst_waddr", 32'(b8.out_waddr), 0);
    chk("rst_raddr", 32'(b8.out_raddr), 0);
    chk("rst_filled", 32'(b8.out_filled), 0);
    tick("rst", 1'b0);
    tick("rst", 1'b0);
    rst = 1'b0;

    // Fill with 0..7: waddr wraps and filled sets.
    b8.in_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b8.in_wdata = 8'(i);
      tick("wr", 1'b0);
    end
    chk("wr_filled_end", 32'(b8.out_filled), 1);

    // Reset keeps data; read back 0..7 and wrap.
    rst = 1'b1;
    b8.in_we = 1'b0;
    tick("rst2", 1'b0);
    rst = 1'b0;
    chk("rd0_rdata", 32'(b8.out_rdata), 0);
    for (int i = 0; i < 8; i++)
      tick("rd", 1'b0);
    chk("rd_wrap", 32'(b8.out_raddr), 0);

    // Overwrite, then reset mid-write at waddr 5.
    b8.in_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b8.in_wdata = 8'h10 + 8'(i);
      tick("wr2", 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      b8.in_wdata = 8'h20 + 8'(i);
      tick("wr3", 1'b0);
    end
    chk("mid_waddr5", 32'(b8.out_waddr), 5);
    rst = 1'b1;
    b8.in_wdata = 8'h55;
    #1;
    chk("async_waddr", 32'(b8.out_waddr), 0);
    chk("async_raddr", 32'(b8.out_raddr), 0);
    chk("async_filled", 32'(b8.out_filled), 0);
    for (int i = 0; i < 3; i++)
      tick("rst3", 1'b0);
    rst = 1'b0;
    b8.in_we = 1'b0;
    chk("keep_rdata0", 32'(b8.out_rdata),
        REG ? 32'h00 : 32'h20);
    for (int i = 0; i < 8; i++)
      tick("keep", 1'b0);

    // Load 6 with we high: no write; then wrap.
    b8.in_load = 1'b1; b8.in_addr = 3'd6;
    b8.in_we = 1'b1; b8.in_wdata = 8'h99;
    tick("ld", 1'b0);
    chk("ld_waddr", 32'(b8.out_waddr), 6);
    chk("ld_raddr", 32'(b8.out_raddr), 6);
    b8.in_load = 1'b0;
    b8.in_wdata = 8'hAA;
    tick("ldwa", 1'b0);
    b8.in_wdata = 8'hBB;
    tick("ldwb", 1'b0);
    chk("ld_wrap", 32'(b8.out_waddr), 0);
    chk("ld_filled", 32'(b8.out_filled), 1);
    b8.in_load = 1'b1; b8.in_we = 1'b0;
    tick("ld2", 1'b0);
    b8.in_load = 1'b0;
    tick("ldrd", 1'b0);
    tick("ldrd", 1'b0);
    tick("ldrd", 1'b0);

    // Five-entry instance: wrap 4->0, out-of-range load.
    rst = 1'b1;
    b5.in_load = 1'b0; b5.in_we = 1'b1;
    tick("e5rst", 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b5.in_wdata = 8'h30 + 8'(i);
      tick("e5wr", 1'b1);
    end
    chk("e5_wrap", 32'(b5.out_waddr), 0);
    chk("e5_filled", 32'(b5.out_filled), 1);
    b5.in_load = 1'b1; b5.in_addr = 3'd3; b5.in_we = 1'b0;
    tick("e5ld3", 1'b1);
    b5.in_addr = 3'd6;
    tick("e5ld6", 1'b1);
    chk("e5_ld6_raddr", 32'(b5.out_raddr), 0);
    b5.in_addr = 3'd3;
    tick("e5ld3b", 1'b1);
    b5.in_load = 1'b0;
    for (int i = 0; i < 3; i++)
      tick("e5rd", 1'b1);
    chk("e5_rd_wrap", 32'(b5.out_raddr), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
